sys_array_stream_loader: RTL and testbench
==========================================

Name: sys_array_stream_loader

Overview:
- Receives operand matrices A and B as a serial element stream with a valid/ready handshake and converts them into the parallel matrix buses consumed by sys_array_fetcher.
- Sequences the fetcher's load_params/start_comp controls and waits for its ready flag before accepting the next frame.
- It is the serial-to-parallel input side of the array, the opposite end from the result parallel-to-serial output path.

Parameters:
DATA_WIDTH, 8, width of one matrix element
ARRAY_W, 5, rows of A and B (array dimension)
ARRAY_L, 2, columns of A and B (inner dimension); N = ARRAY_W*ARRAY_L elements per matrix

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  stream element valid
in_ready  out  1  loader can accept an element
in_data  in  DATA_WIDTH  stream element
in_last  in  1  marks the final element of a frame (last B element)
comp_ready  in  1  fetcher ready (high = idle/result valid)
data_a  out  N*DATA_WIDTH  matrix A, packed [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]
data_b  out  N*DATA_WIDTH  matrix B, same packing
load_params  out  1  one-cycle pulse to fetcher
start_comp  out  1  one-cycle pulse to fetcher
frame_done  out  1  one-cycle pulse when the fetcher reports completion
frame_error  out  1  one-cycle pulse on a framing error

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - state=LOAD_A, element index=0, in_ready=1.
  - data_a, data_b, and the shadow A/B registers are all 0.
  - load_params, start_comp, frame_done and frame_error are all 0.
- Transfer rule: a transfer occurs on a rising edge with in_valid&in_ready. in_ready is combinational from state only: 1 in LOAD_A/LOAD_B, 0 elsewhere.
- Element order: row-major. Stream element k (0..N-1) of each matrix is element (i=k/ARRAY_L, j=k%ARRAY_L) and lands in bits [(N-1-k)*DATA_WIDTH +: DATA_WIDTH]. Element 0 is the MSB slice.
- Frame: N A-elements followed by N B-elements, 2N transfers. in_last must be high on transfer 2N-1 only.
- Shadow buffering: transfers write shadow registers only. data_a/data_b update only on the cycle load_params is asserted, so they stay stable during computation.
- FSM:
  - LOAD_A: store element at idx; at idx=N-1 go to LOAD_B, idx<=0; else idx+1.
  - LOAD_B: store element; at idx=N-1 with in_last=1 go to ISSUE_LOAD.
  - ISSUE_LOAD: registered load_params=1 for exactly this cycle. data_a/data_b <= shadow. Next state ISSUE_START.
  - ISSUE_START: start_comp=1 for exactly this cycle. Next state WAIT_BUSY.
  - WAIT_BUSY: wait until comp_ready=0, then go to WAIT_DONE. A stale high ready from the previous frame is ignored.
  - WAIT_DONE: on comp_ready=1, frame_done=1 for one cycle, idx<=0, go to LOAD_A.
- Framing errors:
  - Condition 1: in_last=1 on any transfer before the final B element.
  - Condition 2: final B element transferred with in_last=0.
  - Response to either: frame_error pulses one cycle, shadow contents are discarded (not copied), idx<=0, state<=LOAD_A. The erroneous element is consumed.
  - No load_params or start_comp is issued for that frame.
- Idle cycles: in_valid=0 stalls indefinitely, with no timeout and no change in state or idx.
- Counter: idx width is clog2(N), minimum 1 bit. It never exceeds N-1.
- Control outputs: all are registered; no output depends combinationally on in_valid/in_data except in_ready, which depends on state only.
- Reset mid-frame: the asynchronous clear returns everything to the reset values immediately. Partially loaded data is lost, and data_a/data_b read 0.
- Pulse spacing: load_params and start_comp are never high in the same cycle, and are separated by exactly one cycle edge.

Test Plan:
- Basic frame: W=5, L=2. Stream A=1..10, B=11..20, in_last on the 20th transfer.
  - load_params exactly 1 cycle after transfer 20, start_comp the following cycle.
  - data_a = 0x0102030405060708090A; data_b = 0x0B0C0D0E0F1011121314.
- Throttled stream: random in_valid gaps (about 50% duty), same data -> identical data_a/data_b, and in_ready stays 1 throughout loading.
- Completion handshake: comp_ready held high at start_comp, drop it 3 cycles later, raise it 10 cycles later.
  - frame_done pulses once, 1 cycle after the rise.
  - in_ready is 0 until then and 1 the cycle after frame_done.
- Early in_last: assert in_last on transfer 7.
  - frame_error pulses once; no load_params.
  - data_a/data_b keep the previous frame's values.
  - A following clean frame loads correctly.
- Missing in_last: 20 transfers with in_last=0 -> frame_error on the 20th, state returns to LOAD_A, and no start_comp.
- Reset mid-frame: assert reset_n=0 asynchronously (between edges) after transfer 13.
  - All outputs are 0 immediately and in_ready=1 (reset values, in_ready tied to LOAD_A).
  - A full frame after release loads correctly.

Source files
------------

// File: rtl/sys_array_stream_loader.sv
// sys_array_stream_loader
// Serial-to-parallel front end of the systolic array. Collects matrix A then
// matrix B from a valid/ready element stream into shadow registers. On a clean
// frame it publishes them on data_a/data_b together with a load_params pulse,
// then issues start_comp. It then waits for the fetcher to go busy and back to
// ready before accepting the next frame.
module sys_array_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 5,
    parameter int ARRAY_L    = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_last,
    input  logic                                   comp_ready,
    output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]  data_a,
    output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]  data_b,
    output logic                                   load_params,
    output logic                                   start_comp,
    output logic                                   frame_done,
    output logic                                   frame_error
);

    localparam int N     = ARRAY_W * ARRAY_L;
    localparam int MW    = N * DATA_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ISSUE_LOAD,
        ISSUE_START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [MW-1:0]     shadow_a;
    logic [MW-1:0]     shadow_b;
    logic [MW-1:0]     shadow_a_nxt;
    logic [MW-1:0]     shadow_b_nxt;
    logic              xfer;

    assign in_ready = (state == LOAD_A) || (state == LOAD_B);
    assign xfer     = in_valid & in_ready;

    // Shadow contents with the current element merged in at slot idx (element 0 is the MSB slice)
    always_comb begin
        shadow_a_nxt = shadow_a;
        shadow_b_nxt = shadow_b;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) == k) begin
                shadow_a_nxt[(N-1-k)*DATA_WIDTH +: DATA_WIDTH] = in_data;
                shadow_b_nxt[(N-1-k)*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
    end

    // Frame sequencer: loading, fetcher handshake, framing checks and registered pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LOAD_A;
            idx         <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            data_a      <= '0;
            data_b      <= '0;
            load_params <= 1'b0;
            start_comp  <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            load_params <= 1'b0;
            start_comp  <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        shadow_a <= shadow_a_nxt;
                        if (in_last) begin
                            // last marker inside matrix A: drop the frame
                            frame_error <= 1'b1;
                            idx         <= '0;
                        end else if (idx == IDX_LAST) begin
                            state <= LOAD_B;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        shadow_b <= shadow_b_nxt;
                        if (idx == IDX_LAST && in_last) begin
                            // publish with the final element merged so the
                            // buses are valid in the same cycle as load_params
                            data_a      <= shadow_a;
                            data_b      <= shadow_b_nxt;
                            load_params <= 1'b1;
                            idx         <= '0;
                            state       <= ISSUE_LOAD;
                        end else if (idx == IDX_LAST || in_last) begin
                            frame_error <= 1'b1;
                            idx         <= '0;
                            state       <= LOAD_A;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ISSUE_LOAD: begin
                    start_comp <= 1'b1;
                    state      <= ISSUE_START;
                end
                ISSUE_START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // ready still high from the previous frame is not a completion
                    if (!comp_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (comp_ready) begin
                        frame_done <= 1'b1;
                        idx        <= '0;
                        state      <= LOAD_A;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_array_stream_loader.sv
// Bench for sys_array_stream_loader: directed sequence of frames with random
// element values, random stream gaps and random fetcher latencies, checked
// against matrices packed directly from the element arrays.
module tb_sys_array_stream_loader;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int AL = 2;
    localparam int N  = AW * AL;
    localparam int MW = N * DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          comp_ready;
    logic [MW-1:0] data_a;
    logic [MW-1:0] data_b;
    logic          load_params;
    logic          start_comp;
    logic          frame_done;
    logic          frame_error;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_lp = 0, n_sc = 0, n_fd = 0, n_fe = 0, n_overlap = 0;

    logic [DW-1:0] fa [N];
    logic [DW-1:0] fb [N];
    logic [MW-1:0] exp_a = '0;
    logic [MW-1:0] exp_b = '0;

    always #5 clk = ~clk;

    sys_array_stream_loader #(.DATA_WIDTH(DW), .ARRAY_W(AW), .ARRAY_L(AL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .comp_ready (comp_ready),
        .data_a     (data_a),
        .data_b     (data_b),
        .load_params(load_params),
        .start_comp (start_comp),
        .frame_done (frame_done),
        .frame_error(frame_error)
    );

    // pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (load_params) n_lp++;
        if (start_comp) n_sc++;
        if (frame_done) n_fd++;
        if (frame_error) n_fe++;
        if (load_params && start_comp) n_overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // row-major element list -> bus with element 0 in the top slice
    function automatic logic [MW-1:0] pack(input bit sel_b);
        logic [MW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r = (r << DW) | MW'(sel_b ? fb[k] : fa[k]);
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            fa[k] = DW'($urandom_range(255, 0));
            fb[k] = DW'($urandom_range(255, 0));
        end
    endtask

    // one element; optional idle gap first; transfer occurs on the next edge
    task automatic send(input logic [DW-1:0] d, input logic last, input bit thr);
        int guard;
        if (thr) begin
            repeat ($urandom_range(2, 0)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                chk1("ready_in_gap", in_ready, 1'b1);
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk1("ready_at_xfer", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit thr);
        for (int k = 0; k < N; k++) send(fa[k], 1'b0, thr);
        for (int k = 0; k < N; k++) send(fb[k], (k == N - 1), thr);
    endtask

    // called one cycle after the final transfer; ends in the start_comp cycle
    task automatic check_issue();
        exp_a = pack(1'b0);
        exp_b = pack(1'b1);
        chk1("load_params_hi", load_params, 1'b1);
        chk1("start_comp_lo", start_comp, 1'b0);
        chkw("data_a", data_a, exp_a);
        chkw("data_b", data_b, exp_b);
        chk1("ready_issue", in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("load_params_lo", load_params, 1'b0);
        chk1("start_comp_hi", start_comp, 1'b1);
    endtask

    // fetcher stays ready for d1 cycles, goes busy for d2 cycles, then ready
    task automatic complete(input int d1, input int d2);
        int fd0;
        fd0 = n_fd;
        repeat (d1) begin
            @(posedge clk); #1;
            chk1("ready_busy", in_ready, 1'b0);
            chk1("start_comp_once", start_comp, 1'b0);
            chk1("no_early_done", frame_done, 1'b0);
        end
        comp_ready = 1'b0;
        repeat (d2) begin
            @(posedge clk); #1;
            chk1("ready_busy", in_ready, 1'b0);
            chk1("no_early_done", frame_done, 1'b0);
        end
        comp_ready = 1'b1;
        @(posedge clk); #1;
        chk1("frame_done_hi", frame_done, 1'b1);
        @(posedge clk); #1;
        chk1("frame_done_lo", frame_done, 1'b0);
        chk1("ready_after_done", in_ready, 1'b1);
        chki("frame_done_count", n_fd - fd0, 1);
        chkw("data_a_hold", data_a, exp_a);
        chkw("data_b_hold", data_b, exp_b);
    endtask

    task automatic full_frame(input bit thr, input int d1, input int d2);
        send_frame(thr);
        check_issue();
        complete(d1, d2);
    endtask

    task automatic check_reset_values(input string tag);
        chkw({tag, "_data_a"}, data_a, '0);
        chkw({tag, "_data_b"}, data_b, '0);
        chk1({tag, "_load_params"}, load_params, 1'b0);
        chk1({tag, "_start_comp"}, start_comp, 1'b0);
        chk1({tag, "_frame_done"}, frame_done, 1'b0);
        chk1({tag, "_frame_error"}, frame_error, 1'b0);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int lp0, sc0, fe0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        comp_ready = 1'b1;

        // reset state
        #12;
        check_reset_values("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // basic frame A=1..10, B=11..20
        for (int k = 0; k < N; k++) begin
            fa[k] = DW'(k + 1);
            fb[k] = DW'(k + 11);
        end
        send_frame(1'b0);
        chkw("basic_a_const", data_a, 80'h0102030405060708090A);
        chkw("basic_b_const", data_b, 80'h0B0C0D0E0F1011121314);
        check_issue();
        complete(3, 10);

        // throttled stream, same data
        full_frame(1'b1, $urandom_range(5, 1), $urandom_range(8, 1));

        // early in_last on transfer 7
        fill_random();
        lp0 = n_lp; fe0 = n_fe;
        for (int k = 0; k < 7; k++) send(fa[k], (k == 6), 1'b0);
        chk1("early_error_hi", frame_error, 1'b1);
        chk1("early_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk1("early_error_lo", frame_error, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chki("early_no_load", n_lp - lp0, 0);
        chki("early_error_count", n_fe - fe0, 1);
        chkw("early_keep_a", data_a, exp_a);
        chkw("early_keep_b", data_b, exp_b);
        fill_random();
        full_frame(1'b0, 2, 4);

        // missing in_last on the 20th transfer
        fill_random();
        lp0 = n_lp; sc0 = n_sc; fe0 = n_fe;
        for (int k = 0; k < 2 * N; k++) send((k < N) ? fa[k] : fb[k - N], 1'b0, 1'b0);
        chk1("missing_error_hi", frame_error, 1'b1);
        chk1("missing_ready", in_ready, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chki("missing_no_load", n_lp - lp0, 0);
        chki("missing_no_start", n_sc - sc0, 0);
        chki("missing_error_count", n_fe - fe0, 1);
        chkw("missing_keep_a", data_a, exp_a);
        fill_random();
        full_frame(1'b1, 1, 2);

        // asynchronous reset after transfer 13
        fill_random();
        for (int k = 0; k < 13; k++) send((k < N) ? fa[k] : fb[k - N], 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_a = '0;
        exp_b = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        fill_random();
        full_frame(1'b0, 1, 1);

        // assorted random frames
        for (int f = 0; f < 4; f++) begin
            fill_random();
            full_frame(bit'($urandom_range(1, 0)), $urandom_range(6, 1), $urandom_range(12, 1));
        end

        chki("pulse_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
